// File: rtl/dw_layer_sequencer_if.sv
// Stream handshake bundle shared by the upstream source, the depthwise layer and its sequencer.
interface dw_layer_sequencer_if;
  logic up_tvalid;
  logic up_tready;
  logic dn_tvalid;
  logic dn_tready;
  logic mon_tvalid;
  logic mon_tready;

  modport master (
    input  up_tvalid,
    input  dn_tready,
    input  mon_tvalid,
    input  mon_tready,
    output up_tready,
    output dn_tvalid
  );

  modport slave (
    output up_tvalid,
    output dn_tready,
    output mon_tvalid,
    output mon_tready,
    input  up_tready,
    input  dn_tvalid
  );
endinterface

// File: rtl/dw_layer_sequencer.sv
// Per-layer sequencer for a depthwise conv block: copies the kernel from weight memory,
// gates exactly one frame of input into the layer, then waits for the layer's output beats.
module dw_layer_sequencer #(
  parameter int DATA_W     = 8,
  parameter int CHANNELS   = 32,
  parameter int IMG_WIDTH  = 224,
  parameter int IMG_HEIGHT = 224,
  parameter int OUT_BEATS  = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2),
  parameter int WT_AW      = 16,
  localparam int K         = CHANNELS * 9,
  localparam int KAW       = $clog2(K)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WT_AW-1:0]     wt_base,
  output logic                 busy,
  output logic                 done,
  output logic                 wt_rd_en,
  output logic [WT_AW-1:0]     wt_rd_addr,
  input  logic [DATA_W-1:0]    wt_rd_data,
  output logic                 kernel_wr_en,
  output logic [KAW-1:0]       kernel_wr_addr,
  output logic [DATA_W-1:0]    kernel_wr_data,
  dw_layer_sequencer_if.master strm
);

  localparam int PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW  = $clog2(PIX + 1);
  localparam int RCW = $clog2(K + 1);

  localparam logic [CW-1:0]  PIX_LIM  = CW'(PIX);
  localparam logic [CW-1:0]  PIX_LAST = CW'(PIX - 1);
  localparam logic [CW-1:0]  OUT_LIM  = CW'(OUT_BEATS);
  localparam logic [CW-1:0]  OUT_LAST = CW'(OUT_BEATS - 1);
  localparam logic [RCW-1:0] K_LIM    = RCW'(K);
  localparam logic [RCW-1:0] ONE_R    = {{(RCW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  ONE_C    = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WT_AW-1:0] base_r;
  logic [RCW-1:0]   rd_cnt_r;
  logic [CW-1:0]    in_cnt_r;
  logic [CW-1:0]    out_cnt_r;
  logic             gate_s;
  logic             in_beat_s;
  logic             out_beat_s;

  assign gate_s     = (state_r == S_STREAM) && (in_cnt_r < PIX_LIM);
  assign in_beat_s  = gate_s && strm.up_tvalid && strm.dn_tready;
  assign out_beat_s = ((state_r == S_STREAM) || (state_r == S_DRAIN)) &&
                      strm.mon_tvalid && strm.mon_tready && (out_cnt_r < OUT_LIM);

  assign strm.up_tready = gate_s && strm.dn_tready;
  assign strm.dn_tvalid = gate_s && strm.up_tvalid;

  // State register and counters; an accepted start re-arms every counter for a fresh layer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      base_r    <= {WT_AW{1'b0}};
      rd_cnt_r  <= {RCW{1'b0}};
      in_cnt_r  <= {CW{1'b0}};
      out_cnt_r <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      if ((state_r == S_IDLE) && start) begin
        base_r    <= wt_base;
        rd_cnt_r  <= {RCW{1'b0}};
        in_cnt_r  <= {CW{1'b0}};
        out_cnt_r <= {CW{1'b0}};
      end else begin
        if ((state_r == S_LOAD) && (rd_cnt_r != K_LIM)) rd_cnt_r <= rd_cnt_r + ONE_R;
        if (in_beat_s) in_cnt_r <= in_cnt_r + ONE_C;
        if (out_beat_s) out_cnt_r <= out_cnt_r + ONE_C;
      end
    end
  end

  // Next state; DRAIN also finishes in the same cycle as the last output beat it sees.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_LOAD;
        else       state_s = S_IDLE;
      end
      S_LOAD: begin
        if (rd_cnt_r == K_LIM) state_s = S_STREAM;
        else                   state_s = S_LOAD;
      end
      S_STREAM: begin
        if ((in_beat_s && (in_cnt_r == PIX_LAST)) || (in_cnt_r == PIX_LIM)) state_s = S_DRAIN;
        else                                                                 state_s = S_STREAM;
      end
      S_DRAIN: begin
        if ((out_cnt_r == OUT_LIM) || (out_beat_s && (out_cnt_r == OUT_LAST))) state_s = S_DONE;
        else                                                                   state_s = S_DRAIN;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Status and kernel-copy outputs; the write trails its read by one cycle of memory latency.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    wt_rd_en       = 1'b0;
    wt_rd_addr     = {WT_AW{1'b0}};
    kernel_wr_en   = 1'b0;
    kernel_wr_addr = {KAW{1'b0}};
    kernel_wr_data = {DATA_W{1'b0}};
    case (state_r)
      S_IDLE: busy = 1'b0;
      S_LOAD: begin
        busy = 1'b1;
        if (rd_cnt_r < K_LIM) begin
          wt_rd_en   = 1'b1;
          wt_rd_addr = base_r + WT_AW'(rd_cnt_r);
        end else begin
          wt_rd_en   = 1'b0;
          wt_rd_addr = {WT_AW{1'b0}};
        end
        if (rd_cnt_r != {RCW{1'b0}}) begin
          kernel_wr_en   = 1'b1;
          kernel_wr_addr = KAW'(rd_cnt_r - ONE_R);
          kernel_wr_data = wt_rd_data;
        end else begin
          kernel_wr_en   = 1'b0;
          kernel_wr_addr = {KAW{1'b0}};
          kernel_wr_data = {DATA_W{1'b0}};
        end
      end
      S_STREAM: busy = 1'b1;
      S_DRAIN:  busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dw_layer_sequencer.sv
// Self-checking bench for dw_layer_sequencer: 2 channels, 4x4 frame, 4 output beats.
module tb_dw_layer_sequencer;
  localparam int DATA_W   = 8;
  localparam int CHANNELS = 2;
  localparam int IMG_W    = 4;
  localparam int IMG_H    = 4;
  localparam int OUT_B    = 4;
  localparam int WT_AW    = 16;
  localparam int K        = CHANNELS * 9;
  localparam int KAW      = $clog2(K);
  localparam int PIX      = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [WT_AW-1:0]  wt_base;
  logic              busy;
  logic              done;
  logic              wt_rd_en;
  logic [WT_AW-1:0]  wt_rd_addr;
  logic [DATA_W-1:0] wt_rd_data = 8'h00;
  logic              kernel_wr_en;
  logic [KAW-1:0]    kernel_wr_addr;
  logic [DATA_W-1:0] kernel_wr_data;

  int checks = 0;
  int errors = 0;

  dw_layer_sequencer_if strm ();

  dw_layer_sequencer #(
    .DATA_W(DATA_W), .CHANNELS(CHANNELS), .IMG_WIDTH(IMG_W), .IMG_HEIGHT(IMG_H),
    .OUT_BEATS(OUT_B), .WT_AW(WT_AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .wt_base(wt_base),
    .busy(busy), .done(done),
    .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
    .kernel_wr_en(kernel_wr_en), .kernel_wr_addr(kernel_wr_addr), .kernel_wr_data(kernel_wr_data),
    .strm(strm)
  );

  always #5 clk = ~clk;

  // Weight memory: mem[a] = a[7:0], one cycle read latency.
  always @(posedge clk) if (wt_rd_en) wt_rd_data <= wt_rd_addr[7:0];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    start           = 1'b0;
    strm.up_tvalid  = 1'b0;
    strm.dn_tready  = 1'b0;
    strm.mon_tvalid = 1'b0;
    strm.mon_tready = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic begin_layer(input logic [WT_AW-1:0] b);
    quiet();
    start   = 1'b1;
    wt_base = b;
    tick();
    start = 1'b0;
    repeat (K + 1) tick();
  endtask

  task automatic test_reset();
    quiet();
    reset          = 1'b1;
    start          = 1'b1;
    wt_base        = 16'h1234;
    strm.up_tvalid = 1'b1;
    strm.dn_tready = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({busy, done, wt_rd_en, kernel_wr_en, strm.up_tready, strm.dn_tvalid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {busy, done, wt_rd_en, kernel_wr_en, strm.up_tready, strm.dn_tvalid});
    end
    checks++;
    if (wt_rd_addr !== 16'h0000 || kernel_wr_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_addr: got %h/%h expected 0/0", wt_rd_addr, kernel_wr_addr);
    end
    reset = 1'b0;
    start = 1'b0;
    tick();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_load(input logic [WT_AW-1:0] base);
    bit seen [K];
    int wr_count;
    logic             exp_rd, exp_wr;
    logic [WT_AW-1:0] exp_addr, src;
    for (int i = 0; i < K; i++) seen[i] = 1'b0;
    wr_count = 0;
    quiet();
    start   = 1'b1;
    wt_base = base;
    tick();
    start = 1'b0;
    for (int c = 0; c <= K; c++) begin
      exp_rd   = (c < K);
      exp_addr = exp_rd ? base + 16'(c) : 16'h0000;
      exp_wr   = (c >= 1);
      src      = base + 16'(c) - 16'd1;
      #1;
      checks++;
      if (wt_rd_en !== exp_rd || wt_rd_addr !== exp_addr || busy !== 1'b1) begin
        errors++;
        $display("FAIL load_read c=%0d: got en=%b addr=%h busy=%b expected en=%b addr=%h busy=1",
                 c, wt_rd_en, wt_rd_addr, busy, exp_rd, exp_addr);
      end
      checks++;
      if (kernel_wr_en !== exp_wr) begin
        errors++;
        $display("FAIL load_wr_en c=%0d: got %b expected %b", c, kernel_wr_en, exp_wr);
      end
      if (exp_wr) begin
        checks++;
        if (kernel_wr_addr !== 5'(c - 1) || kernel_wr_data !== src[7:0]) begin
          errors++;
          $display("FAIL load_write c=%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                   c, kernel_wr_addr, kernel_wr_data, c - 1, src[7:0]);
        end
      end
      if (kernel_wr_en === 1'b1 && kernel_wr_addr < K && !seen[kernel_wr_addr]) begin
        seen[kernel_wr_addr] = 1'b1;
        wr_count++;
      end
      tick();
    end
    #1;
    checks++;
    if (wr_count !== K || wt_rd_en !== 1'b0 || kernel_wr_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_end: got writes=%0d rd=%b wr=%b busy=%b expected writes=%0d rd=0 wr=0 busy=1",
               wr_count, wt_rd_en, kernel_wr_en, busy, K);
    end
    strm.up_tvalid = 1'b1;
    strm.dn_tready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (strm.up_tready !== 1'b1 || strm.dn_tvalid !== 1'b1) begin
        errors++;
        $display("FAIL stream_open c=%0d: got ready=%b valid=%b expected 1/1", c, strm.up_tready, strm.dn_tvalid);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    #1;
    checks++;
    if ({busy, strm.up_tready, strm.dn_tvalid, wt_rd_en, kernel_wr_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_stream: got %b expected 00000",
               {busy, strm.up_tready, strm.dn_tvalid, wt_rd_en, kernel_wr_en});
    end
    reset = 1'b0;
    quiet();
  endtask

  task automatic test_reset_mid_load();
    quiet();
    start   = 1'b1;
    wt_base = 16'h0200;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #1;
    checks++;
    if (wt_rd_en !== 1'b1 || wt_rd_addr !== 16'h0205) begin
      errors++;
      $display("FAIL mid_load_read5: got en=%b addr=%h expected 1/0205", wt_rd_en, wt_rd_addr);
    end
    reset = 1'b1;
    tick();
    #1;
    checks++;
    if (busy !== 1'b0 || kernel_wr_en !== 1'b0 || wt_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_load_reset: got busy=%b wr=%b rd=%b expected 0/0/0", busy, kernel_wr_en, wt_rd_en);
    end
    reset   = 1'b0;
    start   = 1'b1;
    wt_base = 16'h03A0;
    tick();
    start = 1'b0;
    #1;
    checks++;
    if (wt_rd_en !== 1'b1 || wt_rd_addr !== 16'h03A0 || kernel_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reload_r0: got rd=%b addr=%h wr=%b expected 1/03a0/0", wt_rd_en, wt_rd_addr, kernel_wr_en);
    end
    tick();
    #1;
    checks++;
    if (kernel_wr_en !== 1'b1 || kernel_wr_addr !== 5'd0 || kernel_wr_data !== 8'hA0) begin
      errors++;
      $display("FAIL reload_w0: got wr=%b addr=%0d data=%h expected 1/0/a0",
               kernel_wr_en, kernel_wr_addr, kernel_wr_data);
    end
    do_reset();
  endtask

  task automatic test_full_frame();
    logic exp_open, exp_done, exp_busy;
    begin_layer(16'h0100);
    strm.up_tvalid = 1'b1;
    strm.dn_tready = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      strm.mon_tvalid = (c >= 16);
      strm.mon_tready = (c >= 16);
      #1;
      exp_open = (c < PIX);
      exp_done = (c == 20);
      exp_busy = (c <= 20);
      checks++;
      if (strm.up_tready !== exp_open || strm.dn_tvalid !== exp_open) begin
        errors++;
        $display("FAIL frame_gate c=%0d: got ready=%b valid=%b expected %b", c, strm.up_tready, strm.dn_tvalid, exp_open);
      end
      checks++;
      if (done !== exp_done || busy !== exp_busy) begin
        errors++;
        $display("FAIL frame_done c=%0d: got done=%b busy=%b expected done=%b busy=%b",
                 c, done, busy, exp_done, exp_busy);
      end
      tick();
    end
    quiet();
  endtask

  task automatic test_coincident();
    int pulses;
    logic exp_done, exp_busy;
    pulses = 0;
    begin_layer(16'h0777);
    strm.up_tvalid = 1'b1;
    strm.dn_tready = 1'b1;
    for (int c = 0; c <= 19; c++) begin
      strm.mon_tvalid = (c >= 12 && c <= 15);
      strm.mon_tready = 1'b1;
      #1;
      exp_done = (c == 17);
      exp_busy = (c <= 17);
      if (done === 1'b1) pulses++;
      checks++;
      if (done !== exp_done || busy !== exp_busy) begin
        errors++;
        $display("FAIL coincident c=%0d: got done=%b busy=%b expected done=%b busy=%b",
                 c, done, busy, exp_done, exp_busy);
      end
      tick();
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL coincident_pulses: got %0d expected 1", pulses);
    end
    quiet();
  endtask

  task automatic test_start_held();
    logic exp_done, exp_busy, exp_rd;
    quiet();
    start   = 1'b1;
    wt_base = 16'h0040;
    tick();
    repeat (K + 1) tick();
    strm.up_tvalid = 1'b1;
    strm.dn_tready = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      strm.mon_tvalid = (c < 4);
      strm.mon_tready = 1'b1;
      #1;
      exp_done = (c == 17);
      exp_busy = (c != 18);
      exp_rd   = (c >= 19);
      checks++;
      if (done !== exp_done || busy !== exp_busy || wt_rd_en !== exp_rd) begin
        errors++;
        $display("FAIL start_held c=%0d: got done=%b busy=%b rd=%b expected %b/%b/%b",
                 c, done, busy, wt_rd_en, exp_done, exp_busy, exp_rd);
      end
      if (exp_rd) begin
        checks++;
        if (wt_rd_addr !== 16'h0040 + 16'(c - 19)) begin
          errors++;
          $display("FAIL start_held_addr c=%0d: got %h expected %h", c, wt_rd_addr, 16'h0040 + 16'(c - 19));
        end
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_random_stream();
    int   passed, outs, t_in, t_out, dcyc, mp;
    logic v, r, mv, mr, exp_open, exp_done;
    bit   finished;
    for (int l = 0; l < 4; l++) begin
      mp = 15 + 25 * l;
      begin_layer(16'($urandom));
      passed   = 0;
      outs     = 0;
      t_in     = -1;
      t_out    = -1;
      finished = 1'b0;
      for (int c = 0; c < 300 && !finished; c++) begin
        v  = ($urandom_range(99) < 70);
        r  = ($urandom_range(99) < 60);
        mv = ($urandom_range(99) < mp);
        mr = ($urandom_range(99) < 70);
        strm.up_tvalid  = v;
        strm.dn_tready  = r;
        strm.mon_tvalid = mv;
        strm.mon_tready = mr;
        #1;
        dcyc     = (t_in >= 0 && t_out >= 0) ? ((t_in + 2 > t_out + 1) ? t_in + 2 : t_out + 1) : -1;
        exp_open = (t_in < 0);
        exp_done = (c == dcyc);
        checks++;
        if (strm.up_tready !== (exp_open && r) || strm.dn_tvalid !== (exp_open && v)) begin
          errors++;
          $display("FAIL rand_gate l=%0d c=%0d: got ready=%b valid=%b expected %b/%b",
                   l, c, strm.up_tready, strm.dn_tvalid, exp_open && r, exp_open && v);
        end
        checks++;
        if (done !== exp_done || busy !== 1'b1) begin
          errors++;
          $display("FAIL rand_done l=%0d c=%0d: got done=%b busy=%b expected done=%b busy=1",
                   l, c, done, busy, exp_done);
        end
        if (exp_open && v && r) begin
          passed++;
          if (passed == PIX) t_in = c;
        end
        if (outs < OUT_B && mv && mr && (dcyc < 0 || c < dcyc)) begin
          outs++;
          if (outs == OUT_B) t_out = c;
        end
        if (exp_done) finished = 1'b1;
        tick();
      end
      checks++;
      if (!finished) begin
        errors++;
        $display("FAIL rand_timeout l=%0d: got no done expected done within 300 cycles", l);
      end
      quiet();
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL rand_idle l=%0d: got busy=%b done=%b expected 0/0", l, busy, done);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    wt_base = 16'h0000;
    quiet();
    test_reset();
    test_load(16'h0100);
    test_load(16'hFFF8);
    test_reset_mid_load();
    test_full_frame();
    test_coincident();
    test_start_held();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dw_layer_sequencer.md
DW_LAYER_SEQUENCER -- requirements
Module: dw_layer_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning pixel/weight width in bits.
REQ-002 SHALL have parameter CHANNELS, default 32, meaning depthwise channel count; K = CHANNELS*9 kernel words.
REQ-003 SHALL have parameter IMG_WIDTH, default 224, meaning input frame width in pixels.
REQ-004 SHALL have parameter IMG_HEIGHT, default 224, meaning input frame height in rows.
REQ-005 SHALL have parameter OUT_BEATS, default (IMG_WIDTH-2)*(IMG_HEIGHT-2), meaning expected output beats per frame.
REQ-006 SHALL have parameter WT_AW, default 16, meaning weight-memory address width; KAW = $clog2(K).
REQ-007 Ports: clk input 1 clock; reset input 1 (reset reset, synchronous, active-high; clock clk).
REQ-008 Ports: start input 1 (begin layer); wt_base input WT_AW (weight base address, sampled on accepted start); busy output 1; done output 1 (one-cycle pulse).
REQ-009 Ports: wt_rd_en output 1; wt_rd_addr output WT_AW; wt_rd_data input DATA_W (weight memory, fixed 1-cycle read latency).
REQ-010 Ports: kernel_wr_en output 1; kernel_wr_addr output KAW; kernel_wr_data output DATA_W (to the depthwise layer kernel file).
REQ-011 Ports: up_tvalid input 1; up_tready output 1 (upstream source handshake); dn_tvalid output 1; dn_tready input 1 (layer s_axis handshake; data bypasses this block).
REQ-012 Ports: mon_tvalid input 1; mon_tready input 1 (passive monitor of the layer m_axis handshake).

Function
REQ-013 FSM states IDLE, LOAD, STREAM, DRAIN, DONE; reset state IDLE.
REQ-014 IDLE: start=1 -> LOAD, latch wt_base, clear all counters; start ignored in any other state.
REQ-015 LOAD: read counter r = 0..K-1, one per cycle, wt_rd_en=1, wt_rd_addr = wt_base + r (modulo 2^WT_AW).
REQ-016 LOAD: cycle after each read, kernel_wr_en=1, kernel_wr_addr = r-1 of that read, kernel_wr_data = wt_rd_data; unregistered data pass-through.
REQ-017 LOAD -> STREAM on the cycle that issues write K-1; LOAD lasts exactly K+1 cycles; exactly K writes, no duplicates.
REQ-018 STREAM: dn_tvalid = up_tvalid, up_tready = dn_tready, both gated by in_cnt < IMG_WIDTH*IMG_HEIGHT; otherwise both 0.
REQ-019 in_cnt increments on each up_tvalid&&dn_tready beat while gated open; holds when valid or ready low.
REQ-020 out_cnt increments on every mon_tvalid&&mon_tready beat in STREAM or DRAIN.
REQ-021 STREAM -> DRAIN when in_cnt reaches IMG_WIDTH*IMG_HEIGHT; if the final output beat occurs in the same cycle, still go DRAIN for one cycle, then DONE.
REQ-022 DRAIN: input gate closed; -> DONE on the cycle after out_cnt reaches OUT_BEATS.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; start during DONE ignored.
REQ-024 busy = 1 in LOAD, STREAM, DRAIN, DONE; 0 in IDLE.
REQ-025 Outside LOAD, wt_rd_en=0 and kernel_wr_en=0; outside STREAM, up_tready=0 and dn_tvalid=0.
REQ-026 Counters sized $clog2(IMG_WIDTH*IMG_HEIGHT+1) bits; no wrap in a legal frame; out beats beyond OUT_BEATS ignored.

Reset
REQ-027 reset=1 at any clock edge, including mid-LOAD or mid-STREAM: state IDLE, all counters 0; busy, done, wt_rd_en, kernel_wr_en, up_tready, dn_tvalid = 0; address outputs 0.
REQ-028 No in-flight kernel write completes after reset is sampled.

Verification
REQ-029 CHANNELS=2, wt_base=0x100, mem[a]=a[7:0]: start -> 19 cycles LOAD; writes addr 0..17, data 0x00..0x11, each one cycle after read.
REQ-030 IMG 4x4, OUT_BEATS=4, dn_tready=1, up_tvalid=1: exactly 16 input beats pass, up_tready=0 from beat 17; 4 mon beats -> done pulse one cycle later.
REQ-031 Random dn_tready/up_tvalid toggling: in_cnt equals handshake count; up_tready never 1 when dn_tready=0.
REQ-032 reset asserted at LOAD read 5: next cycle busy=0, kernel_wr_en=0; new start reloads from r=0.
REQ-033 start held high through a full layer: second layer begins only from IDLE, one cycle after the done pulse.
REQ-034 Final input beat and 4th output beat in same cycle: STREAM -> DRAIN -> DONE, done asserted exactly once.
